fifo_fwft_unpacker: RTL

Downstream consumer for a first-word-fall-through FIFO. It pops wide words from the FIFO read side and serializes each word into `NUM_SPLIT` narrow slices on a valid/ready output stream. Typical use is between a wide memory-read FIFO and a narrow processing-element input.

---
 rtl/fifo_fwft_unpacker_if.sv | 26 ++
 rtl/fifo_fwft_unpacker.sv | 59 +++++
 2 files changed

// File: rtl/fifo_fwft_unpacker_if.sv
// FWFT FIFO read side plus narrow valid/ready slice stream of the unpacker.
// master is the unpacker; slave is the FIFO/consumer environment.
interface fifo_fwft_unpacker_if #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16
);
  logic [IN_WIDTH-1:0]  fifo_data;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 flush;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;

  modport master (
    input  fifo_data, fifo_empty, flush, out_ready,
    output fifo_pop, out_data, out_valid, out_last, busy
  );

  modport slave (
    output fifo_data, fifo_empty, flush, out_ready,
    input  fifo_pop, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/fifo_fwft_unpacker.sv
// Pops wide FWFT FIFO words and emits NUM_SPLIT narrow slices each; slice 0 one cycle after pop.
// Stalls (holding slice and last) while out_ready is low; next pop overlaps the last slice.
module fifo_fwft_unpacker #(
  parameter int    IN_WIDTH  = 64,
  parameter int    OUT_WIDTH = 16,
  parameter int    NUM_SPLIT = IN_WIDTH / OUT_WIDTH,
  parameter int    CNT_WIDTH = (NUM_SPLIT > 1) ? $clog2(NUM_SPLIT) : 1,
  parameter string ORDER     = "LSB_FIRST"
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_fwft_unpacker_if.master bus
);

  localparam bit                   MSB_FIRST = (ORDER == "MSB_FIRST");
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(NUM_SPLIT - 1);

  logic [IN_WIDTH-1:0]  hold;
  logic                 hold_valid;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 last;
  logic                 accept;
  logic                 done;
  logic                 pop;

  assign last   = hold_valid && (cnt == LAST_CNT);
  assign accept = hold_valid && bus.out_ready;
  assign done   = accept && last;
  // Gated by reset so a non-empty FIFO is never popped while the block is held in reset.
  assign pop    = reset && !bus.fifo_empty && !bus.flush && (!hold_valid || done);

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = hold_valid;
  assign bus.busy      = hold_valid;
  assign bus.out_last  = last;
  assign bus.out_data  = MSB_FIRST ? hold[IN_WIDTH-1 -: OUT_WIDTH] : hold[OUT_WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      cnt        <= '0;
    end else if (bus.flush) begin
      hold_valid <= 1'b0;
      cnt        <= '0;
    end else if (pop) begin
      hold       <= bus.fifo_data;
      hold_valid <= 1'b1;
      cnt        <= '0;
    end else if (done) begin
      hold_valid <= 1'b0;
      cnt        <= '0;
    end else if (accept) begin
      cnt  <= cnt + CNT_WIDTH'(1);
      hold <= MSB_FIRST ? (hold << OUT_WIDTH) : (hold >> OUT_WIDTH);
    end
  end

endmodule
